// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-master arbiter in front of a single-port SDRAM controller.
// Port 0 is the instruction master and port 1 is the data master. One
// transaction is in flight at a time. A granted request is presented on h_*
// with cs held high until the controller pulses h_compl. The granted master
// then sees a one-cycle ack, followed by a one-cycle holdoff before the next
// arbitration.
//
// Ports:
//   clk, rst_n          single rising-edge clock; synchronous active-low reset
//   mN_access           request, held until mN_ack
//   mN_addr/wdata       word address [31:2] and write data
//   mN_wr_en/bytesel    1 = write; active-high byte enables
//   mN_ack/mN_rdata     one-cycle completion; rdata is valid only with ack, else 0
//   cs, h_*             request to the SDRAM controller (meaningful while cs=1)
//   h_rdata, h_compl    controller read data and completion pulse
//   h_config_done       controller initialisation finished
//
// Build option: SDRAM_ARB_FIXED_PRIO_EN. When it is defined, port 1 always
// wins a tie. When it is undefined, ties alternate round-robin.
module sdram_arbiter #(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_access,
    input  logic [31:2] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wr_en,
    input  logic [3:0]  m0_bytesel,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_access,
    input  logic [31:2] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wr_en,
    input  logic [3:0]  m1_bytesel,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        cs,
    output logic [31:2] h_addr,
    output logic [31:0] h_wdata,
    output logic        h_wr_en,
    output logic [3:0]  h_bytesel,
    input  logic [31:0] h_rdata,
    input  logic        h_compl,
    input  logic        h_config_done
);

    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {
        ST_WAIT_CFG,
        ST_IDLE,
        ST_BUSY,
        ST_ACK,
        ST_HOLDOFF
    } state_t;

    state_t             state;
    // Port of the current or most recent grant. Without fixed priority this
    // register is also the round-robin pointer.
    logic [PORT_W-1:0]  grant_port;
    logic [PORT_W-1:0]  pick;

    // Arbitration choice for this cycle.
    always_comb begin
        pick = PORT_W'(0);
        if (m0_access && m1_access) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            pick = PORT_W'(1);
`else
            pick = ~grant_port;
`endif
        end else if (m1_access) begin
            pick = PORT_W'(1);
        end
    end

    // State machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_WAIT_CFG;
            grant_port <= PORT_W'(1);
            cs         <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            h_addr     <= '0;
            h_wdata    <= '0;
            h_wr_en    <= 1'b0;
            h_bytesel  <= '0;
        end else begin
            // ack and rdata are single-cycle pulses unless set below.
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            case (state)
                ST_WAIT_CFG: begin
                    if (h_config_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (m0_access || m1_access) begin
                        grant_port <= pick;
                        cs         <= 1'b1;
                        state      <= ST_BUSY;
                        if (pick == PORT_W'(1)) begin
                            h_addr    <= m1_addr;
                            h_wdata   <= m1_wdata;
                            h_wr_en   <= m1_wr_en;
                            h_bytesel <= m1_bytesel;
                        end else begin
                            h_addr    <= m0_addr;
                            h_wdata   <= m0_wdata;
                            h_wr_en   <= m0_wr_en;
                            h_bytesel <= m0_bytesel;
                        end
                    end
                end
                ST_BUSY: begin
                    if (h_compl) begin
                        cs    <= 1'b0;
                        state <= ST_ACK;
                        // Writes return zero data to the master.
                        if (grant_port == PORT_W'(1)) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= h_wr_en ? 32'h0 : h_rdata;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= h_wr_en ? 32'h0 : h_rdata;
                        end
                    end
                end
                ST_ACK: begin
                    state <= ST_HOLDOFF;
                end
                // Skips one arbitration so a master that is just dropping
                // access is not granted again.
                ST_HOLDOFF: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_WAIT_CFG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: cycle vector table, a tie-break
// sequence, and randomized transactions checked against a request-level model.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_access, m1_access;
    logic [31:2] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_wr_en, m1_wr_en;
    logic [3:0]  m0_bytesel, m1_bytesel;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cs;
    logic [31:2] h_addr;
    logic [31:0] h_wdata;
    logic        h_wr_en;
    logic [3:0]  h_bytesel;
    logic [31:0] h_rdata;
    logic        h_compl;
    logic        h_config_done;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_access(m0_access), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wr_en(m0_wr_en), .m0_bytesel(m0_bytesel), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_access(m1_access), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wr_en(m1_wr_en), .m1_bytesel(m1_bytesel), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .cs(cs), .h_addr(h_addr), .h_wdata(h_wdata), .h_wr_en(h_wr_en),
        .h_bytesel(h_bytesel), .h_rdata(h_rdata), .h_compl(h_compl),
        .h_config_done(h_config_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus and the outputs expected just after that edge.
    typedef struct {
        logic        rst, cfg, a0, a1, w0, w1, cmp;
        logic [31:0] hrd;
        logic        ecs, ea0, ea1;
        logic [31:0] erd0, erd1;
        logic        ehw;
        int          gp;
    } vec_t;

    function automatic vec_t row(logic rst, logic cfg, logic a0, logic a1, logic w0,
                                 logic w1, logic cmp, logic [31:0] hrd, logic ecs,
                                 logic ea0, logic ea1, logic [31:0] erd0,
                                 logic [31:0] erd1, logic ehw, int gp);
        vec_t v;
        v.rst = rst; v.cfg = cfg; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
        v.cmp = cmp; v.hrd = hrd; v.ecs = ecs; v.ea0 = ea0; v.ea1 = ea1;
        v.erd0 = erd0; v.erd1 = erd1; v.ehw = ehw; v.gp = gp;
        return v;
    endfunction

    // Request-level model state for the randomized phase.
    logic [31:2] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic        r_wr    [2];
    logic [3:0]  r_bs    [2];
    logic        pend    [2];

    task automatic drive(input int p);
        if (p == 0) begin
            m0_access = pend[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0];
            m0_wr_en = r_wr[0]; m0_bytesel = r_bs[0];
        end else begin
            m1_access = pend[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1];
            m1_wr_en = r_wr[1]; m1_bytesel = r_bs[1];
        end
    endtask

    task automatic new_req(input int p);
        r_addr[p]  = 30'($urandom);
        r_wdata[p] = $urandom;
        r_wr[p]    = 1'($urandom_range(0, 1));
        r_bs[p]    = 4'($urandom_range(0, 15));
        pend[p]    = 1'b1;
        drive(p);
    endtask

    vec_t tv[23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  win;
        int  mlast;
        int  lat;
        logic [31:0] rd;
        logic [1:0]  exp_ack;

        rst_n = 1'b0; h_config_done = 1'b0; h_compl = 1'b0; h_rdata = '0;
        m0_access = 1'b0; m1_access = 1'b0;
        m0_addr = 30'h40; m0_wdata = 32'hA5A5_0000; m0_wr_en = 1'b0; m0_bytesel = 4'hF;
        m1_addr = 30'h200; m1_wdata = 32'h1234_5678; m1_wr_en = 1'b1; m1_bytesel = 4'h3;

        //            rst cfg a0 a1 w0 w1 cmp hrd           cs a0 a1 rd0           rd1 hw gp
        tv[0]  = row(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[1]  = row(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[2]  = row(1, 0, 1, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[3]  = row(1, 1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[4]  = row(1, 1, 0, 0, 0, 0, 1, 32'h2222_2222, 0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[5]  = row(1, 1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 0, 0);
        tv[6]  = row(1, 1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 0, 0);
        tv[7]  = row(1, 1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 32'h0, 0, -1);
        tv[8]  = row(1, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[9]  = row(1, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[10] = row(1, 1, 0, 1, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 1, 1);
        tv[11] = row(1, 1, 0, 1, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 1, 1);
        tv[12] = row(1, 1, 0, 1, 0, 1, 1, 32'hCAFE_F00D, 0, 0, 1, 32'h0,        32'h0, 1, -1);
        tv[13] = row(1, 1, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 1, -1);
        tv[14] = row(1, 1, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 1, -1);
        tv[15] = row(1, 1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 0, 0);
        tv[16] = row(0, 1, 1, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[17] = row(1, 0, 1, 0, 0, 1, 1, 32'h3333_3333, 0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[18] = row(1, 1, 1, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[19] = row(1, 1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0, 0, 0);
        tv[20] = row(1, 1, 1, 0, 0, 1, 1, 32'h0000_55AA, 0, 1, 0, 32'h0000_55AA, 32'h0, 0, -1);
        tv[21] = row(1, 1, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);
        tv[22] = row(1, 1, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0, 0, -1);

        for (int i = 0; i < 23; i++) begin
            rst_n = tv[i].rst; h_config_done = tv[i].cfg;
            m0_access = tv[i].a0; m1_access = tv[i].a1;
            m0_wr_en = tv[i].w0; m1_wr_en = tv[i].w1;
            h_compl = tv[i].cmp; h_rdata = tv[i].hrd;
            tick();
            chk($sformatf("v%0d_cs", i), 32'(cs), 32'(tv[i].ecs));
            chk($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(tv[i].ea0));
            chk($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(tv[i].ea1));
            chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tv[i].erd0);
            chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tv[i].erd1);
            chk($sformatf("v%0d_h_wr_en", i), 32'(h_wr_en), 32'(tv[i].ehw));
            if (tv[i].gp == 0) begin
                chk($sformatf("v%0d_h_addr", i), 32'(h_addr), 32'h40);
                chk($sformatf("v%0d_h_wdata", i), h_wdata, 32'hA5A5_0000);
                chk($sformatf("v%0d_h_bytesel", i), 32'(h_bytesel), 32'hF);
            end else if (tv[i].gp == 1) begin
                chk($sformatf("v%0d_h_addr", i), 32'(h_addr), 32'h200);
                chk($sformatf("v%0d_h_wdata", i), h_wdata, 32'h1234_5678);
                chk($sformatf("v%0d_h_bytesel", i), 32'(h_bytesel), 32'h3);
            end
            if (!tv[i].rst) begin
                chk($sformatf("v%0d_rst_h_addr", i), 32'(h_addr), 32'h0);
                chk($sformatf("v%0d_rst_h_wdata", i), h_wdata, 32'h0);
                chk($sformatf("v%0d_rst_h_bytesel", i), 32'(h_bytesel), 32'h0);
            end
        end

        // Both masters request continuously: check the tie-break order.
        rst_n = 1'b0; h_compl = 1'b0; m0_access = 1'b0; m1_access = 1'b0;
        tick();
        rst_n = 1'b1; h_config_done = 1'b1;
        tick();
        m0_wr_en = 1'b0; m1_wr_en = 1'b0;
        m0_access = 1'b1; m1_access = 1'b1;
        for (int t = 0; t < 4; t++) begin
            k = 0;
            while (!cs && k < 20) begin
                tick();
                k++;
            end
            chk($sformatf("tie%0d_cs_wait", t), 32'(cs), 32'h1);
            h_compl = 1'b1; h_rdata = 32'h100 + 32'(t);
            tick();
            h_compl = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            exp_ack = 2'b10;
`else
            exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk($sformatf("tie%0d_order", t), 32'({m1_ack, m0_ack}), 32'(exp_ack));
        end
        m0_access = 1'b0; m1_access = 1'b0;

        // Randomized transactions against the request-level model.
        rst_n = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1; h_config_done = 1'b1;
        tick();
        mlast = 1;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) new_req(p);
            end
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            if (pend[0] && pend[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                win = 1;
`else
                win = 1 - mlast;
`endif
            end else begin
                win = pend[1] ? 1 : 0;
            end
            mlast = win;
            tick();
            chk($sformatf("r%0d_cs_grant", it), 32'(cs), 32'h1);
            chk($sformatf("r%0d_h_addr", it), 32'(h_addr), 32'(r_addr[win]));
            chk($sformatf("r%0d_h_wdata", it), h_wdata, r_wdata[win]);
            chk($sformatf("r%0d_h_wr_en", it), 32'(h_wr_en), 32'(r_wr[win]));
            chk($sformatf("r%0d_h_bytesel", it), 32'(h_bytesel), 32'(r_bs[win]));
            lat = int'($urandom_range(0, 4));
            for (int c = 0; c < lat; c++) begin
                tick();
                chk($sformatf("r%0d_busy_cs", it), 32'(cs), 32'h1);
                chk($sformatf("r%0d_busy_addr", it), 32'(h_addr), 32'(r_addr[win]));
                chk($sformatf("r%0d_busy_ack", it), 32'({m1_ack, m0_ack}), 32'h0);
            end
            rd = $urandom;
            h_compl = 1'b1; h_rdata = rd;
            tick();
            h_compl = 1'b0; h_rdata = $urandom;
            chk($sformatf("r%0d_ack_cs", it), 32'(cs), 32'h0);
            chk($sformatf("r%0d_ack", it), 32'({m1_ack, m0_ack}), (win == 1) ? 32'h2 : 32'h1);
            chk($sformatf("r%0d_rdata_win", it), (win == 1) ? m1_rdata : m0_rdata,
                r_wr[win] ? 32'h0 : rd);
            chk($sformatf("r%0d_rdata_other", it), (win == 1) ? m0_rdata : m1_rdata, 32'h0);
            // Stray completion pulses outside BUSY must be ignored.
            h_compl = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("r%0d_post_ack", it), 32'({m1_ack, m0_ack}), 32'h0);
            chk($sformatf("r%0d_post_cs", it), 32'(cs), 32'h0);
            h_compl = 1'($urandom_range(0, 1));
            tick();
            h_compl = 1'b0;
            chk($sformatf("r%0d_holdoff_cs", it), 32'(cs), 32'h0);
            chk($sformatf("r%0d_holdoff_ack", it), 32'({m1_ack, m0_ack}), 32'h0);
            pend[win] = 1'b0;
            drive(win);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
